// File: rtl/aes_seq_pkg.sv
// Shared types for the AES request sequencer.
// FSM state encoding and default block width.
package aes_seq_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [2:0] {
        IDLE,
        KEY_LD,
        KEY_WAIT,
        TXT_LD,
        TXT_WAIT,
        OUT_HOLD
    } state_e;

endpackage

// File: rtl/aes_key_cache.sv
// Last-expanded-key cache: one key register, a valid bit
// and an equality compare against the incoming request key.
module aes_key_cache
    import aes_seq_pkg::*;
#(
    parameter int BLK_W = AES_BLK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             inv,
    input  logic [BLK_W-1:0] key_in,
    input  logic [BLK_W-1:0] cmp_key,
    output logic             hit
);

    logic [BLK_W-1:0] key_q;
    logic             vld_q;

    // Invalidate wins so an abort can never leave a stale hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q <= '0;
            vld_q <= 1'b0;
        end else if (inv) begin
            vld_q <= 1'b0;
        end else if (wr) begin
            key_q <= key_in;
            vld_q <= 1'b1;
        end
    end

    assign hit = vld_q && (key_q == cmp_key);

endmodule

// File: rtl/aes_req_sequencer.sv
// Request sequencer in front of the AES core: key reuse,
// load pulses, result holding, watchdog and status counters.
module aes_req_sequencer
    import aes_seq_pkg::*;
#(
    parameter int BLK_W   = AES_BLK_W,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [BLK_W-1:0] s_key,
    input  logic [BLK_W-1:0] s_text,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [BLK_W-1:0] m_text,
    output logic             core_kld,
    output logic [BLK_W-1:0] core_key,
    input  logic             core_kdone,
    output logic             core_ld,
    output logic [BLK_W-1:0] core_text_in,
    input  logic             core_done,
    input  logic [BLK_W-1:0] core_text_out,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] blk_cnt,
    output logic [CNT_W-1:0] kld_cnt
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             s_ready_q;
    logic             m_valid_q, m_valid_d;
    logic [BLK_W-1:0] m_text_q, m_text_d;
    logic [BLK_W-1:0] key_q, key_d;
    logic [BLK_W-1:0] text_q, text_d;
    logic             kld_q, ld_q;
    logic             err_q, err_d;
    logic [CNT_W-1:0] blk_q, blk_d;
    logic [CNT_W-1:0] kcnt_q, kcnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             cache_wr, cache_inv, hit;
    logic             expired;

    aes_key_cache #(.BLK_W(BLK_W)) u_cache (
        .clk     (clk),
        .rst     (rst),
        .wr      (cache_wr),
        .inv     (cache_inv),
        .key_in  (key_q),
        .cmp_key (s_key),
        .hit     (hit)
    );

    assign expired = (wd_q == WD_MAX);

    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_text_d  = m_text_q;
        key_d     = key_q;
        text_d    = text_q;
        err_d     = err_clr ? 1'b0 : err_q;
        blk_d     = blk_q;
        kcnt_d    = kcnt_q;
        wd_d      = '0;
        cache_wr  = 1'b0;
        cache_inv = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_valid && s_ready_q) begin
                    key_d   = s_key;
                    text_d  = s_text;
                    state_d = hit ? TXT_LD : KEY_LD;
                end
            end
            KEY_LD: begin
                cache_inv = 1'b1;
                kcnt_d    = kcnt_q + 1'b1;
                state_d   = KEY_WAIT;
            end
            KEY_WAIT: begin
                if (core_kdone) begin
                    cache_wr = 1'b1;
                    state_d  = TXT_LD;
                end else if (expired) begin
                    err_d     = 1'b1;
                    cache_inv = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            TXT_LD: begin
                state_d = TXT_WAIT;
            end
            TXT_WAIT: begin
                if (core_done) begin
                    m_text_d  = core_text_out;
                    m_valid_d = 1'b1;
                    blk_d     = blk_q + 1'b1;
                    state_d   = OUT_HOLD;
                end else if (expired) begin
                    err_d     = 1'b1;
                    cache_inv = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            OUT_HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pulses and s_ready are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_text_q  <= '0;
            key_q     <= '0;
            text_q    <= '0;
            kld_q     <= 1'b0;
            ld_q      <= 1'b0;
            err_q     <= 1'b0;
            blk_q     <= '0;
            kcnt_q    <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= (state_d == IDLE);
            m_valid_q <= m_valid_d;
            m_text_q  <= m_text_d;
            key_q     <= key_d;
            text_q    <= text_d;
            kld_q     <= (state_d == KEY_LD);
            ld_q      <= (state_d == TXT_LD);
            err_q     <= err_d;
            blk_q     <= blk_d;
            kcnt_q    <= kcnt_d;
            wd_q      <= wd_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign m_valid      = m_valid_q;
    assign m_text       = m_text_q;
    assign core_kld     = kld_q;
    assign core_key     = key_q;
    assign core_ld      = ld_q;
    assign core_text_in = text_q;
    assign err          = err_q;
    assign blk_cnt      = blk_q;
    assign kld_cnt      = kcnt_q;

endmodule

// File: tb/tb_aes_req_sequencer.sv
// Directed bench for aes_req_sequencer with a behavioural
// core stand-in (FIPS-197 vector plus a fixed scramble).
module tb_aes_req_sequencer;

    localparam int W    = 128;
    localparam int TO   = 16;
    localparam int CW   = 16;
    localparam int KLAT = 3;
    localparam int DLAT = 4;

    localparam logic [W-1:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [W-1:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [W-1:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [W-1:0] PA     = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [W-1:0] PB     = 128'hdeadbeefcafef00d0badc0de12345678;
    localparam logic [W-1:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [W-1:0] SCR    = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_key = '0;
    logic [W-1:0]  s_text = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_text;
    logic          core_kld;
    logic [W-1:0]  core_key;
    logic          core_kdone;
    logic          core_ld;
    logic [W-1:0]  core_text_in;
    logic          core_done;
    logic [W-1:0]  core_text_out;
    logic          err;
    logic          err_clr = 1'b0;
    logic [CW-1:0] blk_cnt;
    logic [CW-1:0] kld_cnt;

    logic          kdone_m = 1'b0;
    logic          done_m = 1'b0;
    logic          done_s = 1'b0;
    logic          hang = 1'b0;
    logic [W-1:0]  txt_m = '0;
    logic [W-1:0]  key_m = '0;
    logic [W-1:0]  spur_txt = '0;
    int            kc = 0;
    int            dc = 0;
    int            kld_seen = 0;
    int            ld_seen = 0;
    int            n_run = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    aes_req_sequencer #(.BLK_W(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_key         (s_key),
        .s_text        (s_text),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_text        (m_text),
        .core_kld      (core_kld),
        .core_key      (core_key),
        .core_kdone    (core_kdone),
        .core_ld       (core_ld),
        .core_text_in  (core_text_in),
        .core_done     (core_done),
        .core_text_out (core_text_out),
        .err           (err),
        .err_clr       (err_clr),
        .blk_cnt       (blk_cnt),
        .kld_cnt       (kld_cnt)
    );

    function automatic logic [W-1:0] enc(input logic [W-1:0] k, input logic [W-1:0] t);
        if (k == FIPS_K && t == FIPS_P) return FIPS_C;
        return k ^ {t[63:0], t[127:64]} ^ SCR;
    endfunction

    assign core_kdone    = kdone_m;
    assign core_done     = done_m | done_s;
    assign core_text_out = done_s ? spur_txt : txt_m;

    // Core stand-in: ciphertext uses the key actually loaded via kld.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            kdone_m <= 1'b0;
            done_m  <= 1'b0;
            kc      <= 0;
            dc      <= 0;
            key_m   <= '0;
            txt_m   <= '0;
        end else begin
            kdone_m <= 1'b0;
            done_m  <= 1'b0;
            if (core_kld) begin
                key_m <= core_key;
                kc    <= KLAT;
            end else if (kc != 0) begin
                kc      <= kc - 1;
                kdone_m <= (kc == 1);
            end
            if (core_ld && !hang) begin
                dc    <= DLAT;
                txt_m <= enc(key_m, core_text_in);
            end else if (dc != 0) begin
                dc     <= dc - 1;
                done_m <= (dc == 1);
            end
        end
    end

    always @(posedge clk) begin
        if (core_kld) kld_seen <= kld_seen + 1;
        if (core_ld)  ld_seen  <= ld_seen + 1;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] k, input logic [W-1:0] t);
        int n = 0;
        while (s_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", W'(s_ready), W'(1));
        s_valid = 1'b1;
        s_key   = k;
        s_text  = t;
        @(negedge clk);
        s_valid = 1'b0;
        s_key   = ~k;
        s_text  = ~t;
    endtask

    task automatic wait_mv(input string tag);
        int n = 0;
        while (m_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, W'(m_valid), W'(1));
    endtask

    task automatic recv(input string tag, input logic [W-1:0] exp);
        wait_mv(tag);
        check(tag, m_text, exp);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("post_hs_mvalid", W'(m_valid), W'(0));
        check("post_hs_sready", W'(s_ready), W'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int k0;
        int l0;
        repeat (3) @(negedge clk);
        check("rst_sready", W'(s_ready), W'(0));
        check("rst_mvalid", W'(m_valid), W'(0));
        check("rst_err", W'(err), W'(0));
        check("rst_kldcnt", W'(kld_cnt), W'(0));
        check("rst_blkcnt", W'(blk_cnt), W'(0));
        check("rst_mtext", m_text, W'(0));
        rst = 1'b1;
        @(negedge clk);

        // 1: FIPS-197 vector, cold cache
        k0 = kld_seen;
        l0 = ld_seen;
        send(FIPS_K, FIPS_P);
        recv("fips_text", FIPS_C);
        check("fips_kld_pulses", W'(kld_seen - k0), W'(1));
        check("fips_ld_pulses", W'(ld_seen - l0), W'(1));
        check("fips_kldcnt", W'(kld_cnt), W'(1));
        check("fips_blkcnt", W'(blk_cnt), W'(1));

        // 2: same key twice, cache hits
        k0 = kld_seen;
        l0 = ld_seen;
        send(FIPS_K, PA);
        recv("hit_a", enc(FIPS_K, PA));
        send(FIPS_K, PB);
        recv("hit_b", enc(FIPS_K, PB));
        check("hit_kld_pulses", W'(kld_seen - k0), W'(0));
        check("hit_ld_pulses", W'(ld_seen - l0), W'(2));
        check("hit_kldcnt", W'(kld_cnt), W'(1));
        check("hit_blkcnt", W'(blk_cnt), W'(3));

        // 3: backpressure on the result stream
        send(FIPS_K, PB ^ PA);
        wait_mv("bp_mvalid");
        for (int i = 0; i < 10; i++) begin
            check("bp_mtext", m_text, enc(FIPS_K, PB ^ PA));
            check("bp_sready", W'(s_ready), W'(0));
            check("bp_mvalid_hold", W'(m_valid), W'(1));
            @(negedge clk);
        end
        m_ready = 1'b1;
        check("bp_sready_hs", W'(s_ready), W'(0));
        @(negedge clk);
        m_ready = 1'b0;
        check("bp_sready_after", W'(s_ready), W'(1));
        check("bp_mvalid_after", W'(m_valid), W'(0));

        // 4: hung core, watchdog, err_clr collision, cache invalidated
        hang = 1'b1;
        k0 = kld_seen;
        send(FIPS_K, PA);
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            check("wd_err_low", W'(err), W'(0));
            check("wd_no_mvalid", W'(m_valid), W'(0));
            if (i == TO) err_clr = 1'b1;
        end
        @(negedge clk);
        err_clr = 1'b0;
        check("wd_err_set", W'(err), W'(1));
        check("wd_no_mvalid_end", W'(m_valid), W'(0));
        check("wd_idle", W'(s_ready), W'(1));
        check("wd_blkcnt", W'(blk_cnt), W'(4));
        hang = 1'b0;
        check("wd_no_kld_yet", W'(kld_seen - k0), W'(0));
        send(FIPS_K, FIPS_P);
        recv("wd_retry", FIPS_C);
        check("wd_reload_pulse", W'(kld_seen - k0), W'(1));
        check("wd_kldcnt", W'(kld_cnt), W'(2));
        check("wd_err_sticky", W'(err), W'(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", W'(err), W'(0));

        // 5: async reset during KEY_WAIT
        k0 = kld_seen;
        send(K2, PA);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("ar_sready", W'(s_ready), W'(0));
        check("ar_mvalid", W'(m_valid), W'(0));
        check("ar_mtext", m_text, W'(0));
        check("ar_corekey", core_key, W'(0));
        check("ar_kld", W'(core_kld), W'(0));
        check("ar_ld", W'(core_ld), W'(0));
        check("ar_kldcnt", W'(kld_cnt), W'(0));
        check("ar_blkcnt", W'(blk_cnt), W'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(FIPS_K, FIPS_P);
        recv("ar_after", FIPS_C);
        check("ar_kld_pulses", W'(kld_seen - k0), W'(2));
        check("ar_kldcnt_after", W'(kld_cnt), W'(1));
        check("ar_blkcnt_after", W'(blk_cnt), W'(1));

        // 6: spurious core_done in IDLE and OUT_HOLD
        spur_txt = 128'hfeedfacefeedfacefeedfacefeedface;
        done_s = 1'b1;
        @(negedge clk);
        done_s = 1'b0;
        @(negedge clk);
        check("sp_idle_mtext", m_text, FIPS_C);
        check("sp_idle_blkcnt", W'(blk_cnt), W'(1));
        check("sp_idle_mvalid", W'(m_valid), W'(0));
        send(FIPS_K, PB);
        wait_mv("sp_hold_mvalid");
        done_s = 1'b1;
        @(negedge clk);
        done_s = 1'b0;
        @(negedge clk);
        check("sp_hold_mtext", m_text, enc(FIPS_K, PB));
        check("sp_hold_blkcnt", W'(blk_cnt), W'(2));
        recv("sp_hold_recv", enc(FIPS_K, PB));
        check("sp_kldcnt", W'(kld_cnt), W'(1));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
